// File: rtl/tone_meter.sv
// Zero-crossing tone meter: measures period (in samples) and peak/trough per cycle.
// Optional amplitude trackers are built only when TONE_METER_AMP_EN is defined.
module tone_meter #(
  parameter int HYST     = 1024,
  parameter int PERIOD_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [15:0]         din,
  output logic [PERIOD_W-1:0]        period,
  output logic signed [15:0]         peak,
  output logic signed [15:0]         trough,
  output logic                       valid,
  output logic                       ovf
);

  localparam int DATA_W = 16;
  localparam logic signed [DATA_W-1:0] HI   = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] LO   = -HI;
  localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {SYNC, NEG, POS} state_t;

  state_t              state, state_nxt;
  logic                armed;
  logic [PERIOD_W-1:0] cnt;
  logic                at_hi, at_lo, rise;

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + PERIOD_W'(1);
  endfunction

  assign at_hi = (din >= HI);
  assign at_lo = (din <= LO);

  always_comb begin
    state_nxt = state;
    rise      = 1'b0;
    if (en) begin
      case (state)
        SYNC: begin
          if (at_lo)      state_nxt = NEG;
          else if (at_hi) state_nxt = POS;
        end
        NEG: begin
          if (at_hi) begin
            rise      = 1'b1;
            state_nxt = POS;
          end
        end
        POS: begin
          if (at_lo) state_nxt = NEG;
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  // Control: state, arming, sample counter and the period/ovf result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= SYNC;
      armed  <= 1'b0;
      cnt    <= '0;
      period <= '0;
      ovf    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= 1'b0;
      if (en) begin
        if (rise) begin
          cnt   <= '0;
          armed <= 1'b1;
          if (armed) begin
            period <= sat_inc(cnt);
            ovf    <= &cnt;
            valid  <= 1'b1;
          end
        end else begin
          cnt <= sat_inc(cnt);
        end
      end
    end
  end

`ifdef TONE_METER_AMP_EN
  logic signed [DATA_W-1:0] mx, mn;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_W-1:0] smin(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Trackers include the event sample, then restart from the extreme opposite values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mx     <= MINV;
      mn     <= MAXV;
      peak   <= '0;
      trough <= '0;
    end else if (en) begin
      if (rise) begin
        mx <= MINV;
        mn <= MAXV;
        if (armed) begin
          peak   <= smax(mx, din);
          trough <= smin(mn, din);
        end
      end else begin
        mx <= smax(mx, din);
        mn <= smin(mn, din);
      end
    end
  end
`else
  assign peak   = '0;
  assign trough = '0;
`endif

endmodule

// File: tb/tb_tone_meter.sv
// Scoreboard bench for tone_meter: randomized and directed sample streams checked
// against a sample-window reference model; a separate monitor checks every valid.
module tb_tone_meter;
  localparam int HYST = 1024;
  localparam int PW   = 8;
  localparam int PMAX = (1 << PW) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic signed [15:0]  din = '0;
  logic [PW-1:0]       period;
  logic signed [15:0]  peak, trough;
  logic                valid, ovf;

  tone_meter #(.HYST(HYST), .PERIOD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .period(period), .peak(peak), .trough(trough), .valid(valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int period; int pk; int tr; int ovf;} exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int last_period = 0, last_pk = 0, last_tr = 0, last_ovf = 0, n_valid = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: remembers which hysteresis level was crossed last and the
  // samples seen since the previous rising event.
  int side = 0;          // 0 unknown, -1 below -HYST seen last, +1 above +HYST
  bit armed_m = 0;
  int nsamp = 0;
  int wmax = -32768, wmin = 32767;

  task automatic model_reset();
    side = 0; armed_m = 0; nsamp = 0; wmax = -32768; wmin = 32767;
  endtask

  task automatic model(input int s, input int vcyc);
    bit ev;
    exp_t e;
    nsamp++;
    if (s > wmax) wmax = s;
    if (s < wmin) wmin = s;
    ev = 0;
    if (s >= HYST) begin
      ev = (side == -1);
      side = 1;
    end else if (s <= -HYST) begin
      side = -1;
    end
    if (ev) begin
      if (armed_m) begin
        e.cyc    = vcyc;
        e.period = (nsamp > PMAX) ? PMAX : nsamp;
        e.ovf    = (nsamp > PMAX) ? 1 : 0;
`ifdef TONE_METER_AMP_EN
        e.pk = wmax;
        e.tr = wmin;
`else
        e.pk = 0;
        e.tr = 0;
`endif
        q.push_back(e);
      end
      armed_m = 1;
      nsamp = 0;
      wmax = -32768;
      wmin = 32767;
    end
  endtask

  // Monitor: every valid must match the oldest expected result, in the right cycle.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("period", int'(period), e.period);
        chk("peak", int'(peak), e.pk);
        chk("trough", int'(trough), e.tr);
        chk("ovf", int'(ovf), e.ovf);
      end
      last_period = int'(period);
      last_pk     = int'(peak);
      last_tr     = int'(trough);
      last_ovf    = int'(ovf);
    end
  end

  task automatic drive(input int s, input int gap);
    repeat (gap) begin
      en  = 1'b0;
      din = 16'($urandom);
      @(posedge clk); #1;
    end
    en  = 1'b1;
    din = 16'(s);
    model(s, cyc + 1);
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic sq(input int amp, input int nhi, input int nlo, input int reps, input int gap);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < nhi; i++) drive(amp, gap);
      for (int i = 0; i < nlo; i++) drive(-amp, gap);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk("rst_period", int'(period), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_trough", int'(trough), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(ovf), 0);
  endtask

  function automatic int exp_amp(input int v);
`ifdef TONE_METER_AMP_EN
    return v;
`else
    return 0;
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expected results pending", q.size());
    $fatal(1);
  end

  initial begin
    int v0;
    @(posedge clk); #1;
    do_reset();

    // Sub-threshold noise: nothing may be reported.
    for (int i = 0; i < 500; i++) drive((i % 2) ? 1000 : -1000, 0);
    chk("noise_valid_count", n_valid, 0);
    chk("noise_period", int'(period), 0);
    chk("noise_peak", int'(peak), 0);
    chk("noise_trough", int'(trough), 0);

    // Steady square wave, en every cycle.
    sq(8000, 10, 10, 6, 0);
    chk("steady_period", last_period, 20);
    chk("steady_peak", last_pk, exp_amp(8000));
    chk("steady_trough", last_tr, exp_amp(-8000));
    chk("steady_ovf", last_ovf, 0);

    // Sparse strobe: en every third clock.
    sq(8000, 10, 10, 4, 2);
    chk("sparse_period", last_period, 20);

    // Randomized stream with thresholds and extremes, random strobe gaps.
    for (int i = 0; i < 3000; i++) begin
      int s;
      case ($urandom_range(0, 9))
        0: s = HYST;
        1: s = -HYST;
        2: s = HYST - 1;
        3: s = -(HYST - 1);
        4: s = 32767;
        5: s = -32768;
        default: s = int'($signed(16'($urandom)));
      endcase
      drive(s, $urandom_range(0, 2));
    end

    // Counter saturation and the exact saturation boundary.
    sq(5000, 200, 200, 2, 0);
    chk("sat_period", last_period, PMAX);
    chk("sat_ovf", last_ovf, 1);
    sq(5000, 10, 10, 2, 0);
    chk("post_sat_period", last_period, 20);
    chk("post_sat_ovf", last_ovf, 0);
    sq(5000, 128, 127, 2, 0);
    chk("edge_period", last_period, PMAX);
    chk("edge_ovf", last_ovf, 0);
    sq(5000, 128, 128, 2, 0);
    chk("over_edge_ovf", last_ovf, 1);

    // Reset five samples into the positive half of a period.
    sq(8000, 10, 10, 3, 0);
    for (int i = 0; i < 5; i++) drive(8000, 0);
    do_reset();
    v0 = n_valid;
    sq(8000, 10, 10, 3, 0);
    chk("rearm_valid_count", n_valid - v0, 1);
    chk("rearm_period", last_period, 20);

    repeat (4) @(posedge clk);
    #1;
    chk("pending_results", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tone_meter.md
# tone_meter

Sample-stream analyzer for the FIR simulation and bring-up path. It consumes the 16-bit signed audio samples produced by the tone source or the filter output, qualified by the same `en` sample strobe. It detects rising zero crossings with hysteresis and, once per signal period, reports the period length in samples plus the peak and trough amplitude. It sits at the receiving end of the sample stream and lets a bench or on-chip logic confirm the tone frequency and filter attenuation without dumping waveforms.

## Interface
- `HYST`, default 1024: hysteresis threshold. Positive, 1..32767. Compared as signed ±HYST.
- `PERIOD_W`, default 16: width of the sample counter and `period` output.
- `clk` input, 1 bit: system clock. Everything changes on its rising edge.
- `rst_n` input, 1 bit: reset. One clock; reset is synchronous and active-low.
- `en` input, 1 bit: sample strobe. `din` is valid in any cycle where `en`=1.
- `din` input, 16 bits: signed two's-complement sample.
- `period` output, PERIOD_W bits: samples between the last two rising crossings. Saturating.
- `peak` output, 16 bits, signed: maximum sample in the last measured period.
- `trough` output, 16 bits, signed: minimum sample in the last measured period.
- `valid` output, 1 bit: one-cycle pulse when `period`/`peak`/`trough`/`ovf` update.
- `ovf` output, 1 bit: the last reported period saturated the counter.

## Operation
- State machine, 3 states. It advances only in cycles with `en`=1.
  - SYNC (reset state): if `din` <= -HYST, go to NEG. If `din` >= +HYST, go to POS with no event.
  - NEG: if `din` >= +HYST, a rising event occurs; go to POS.
  - POS: if `din` <= -HYST, go to NEG.
- Samples strictly inside (-HYST, +HYST) never change state.
- `armed` flag: cleared at reset, set by the first rising event.
  - The first rising event after reset only sets `armed`, clears the counter and resets the trackers.
  - It produces no `valid`.
- Sample counter `cnt`, PERIOD_W bits:
  - On an `en` sample with no rising event: `cnt` <= `cnt`+1, saturating at all-ones.
  - On an `en` sample that is a rising event: `cnt` <= 0.
- On a rising event with `armed`=1, the outputs load:
  - `period` <= `cnt`+1, saturating. This equals the number of samples after the previous event sample, up to and including the current one.
  - `ovf` <= 1 if `cnt` was already all-ones, else 0.
- Amplitude trackers `mx`/`mn` run over the same window, using signed compares that include the event sample.
  - At an event, `peak`/`trough` load the tracker values merged with the current sample.
  - The trackers then reload to 16'h8000 and 16'h7FFF.
- After reset, or once an event has completed, the trackers start from 16'h8000 (max) and 16'h7FFF (min).
- When `en`=0, no state, counter, tracker or output changes, and `valid`=0.
- Reset mid-period:
  - State returns to SYNC and `armed` clears.
  - The partial period is discarded.
  - The next rising event only re-arms.

## Timing
- Reset values: `period`=0, `peak`=0, `trough`=0, `valid`=0, `ovf`=0. Internally: `cnt`=0, state SYNC, `armed`=0.
- Latency: `valid` rises in the cycle after the clock edge that sampled the event sample with `en`=1. It is high for exactly one clock.
- `period`/`peak`/`trough`/`ovf` change only together with `valid`, and hold until the next `valid`.
- `en` may be asserted every cycle or sparsely. Results depend on the sample count, not on clock count.
- No backpressure: a consumer must capture each result on `valid`.

## Configuration
- `TONE_METER_AMP_EN` defined: the peak/trough trackers are built, and `peak`/`trough` behave as above.
- `TONE_METER_AMP_EN` undefined: no trackers are built, and `peak`/`trough` are constant 0. `period`, `ovf` and `valid` are unchanged.

## Test plan
- **Steady square wave, `en` every cycle:** square ±8000, 10 samples high / 10 low, HYST=1024. The first rising crossing gives no `valid`. Every later rising crossing gives `valid` with `period`=20, `peak`=8000, `trough`=-8000, `ovf`=0.
- **Sparse strobe:** same wave with `en`=1 every 3rd clock. Results are identical (`period`=20). `valid` appears exactly 1 clock after the event `en` cycle, and no `valid` occurs in other cycles.
- **Sub-threshold noise:** alternating +1000/-1000 with HYST=1024 for 500 samples. `valid` never asserts and all outputs stay 0.
- **Counter saturation:** PERIOD_W=16, square ±5000 with half-period 40000 samples. The second rising event reports `period`=65535 and `ovf`=1. A following 20-sample period reports `period`=20 and `ovf`=0.
- **Reset mid-period:** after 2 valid periods, pull `rst_n` low for 1 clock 5 samples into POS. All outputs are 0 the next cycle. The next rising crossing gives no `valid`, and the one after gives `period`=20.
- **Macro undefined:** rerun the steady square-wave test without `TONE_METER_AMP_EN`. `period`=20 as before, and `peak`=`trough`=0.
